// File: rtl/ram_bus_master.sv
// ram_bus_master
//   Initiator for a single-port RAM bus with active-low chip select, output
//   enable, write strobe, address and a shared bidirectional data bus.
//   A host issues single-word reads/writes over a REQ/READY handshake; each
//   transaction occupies three busy cycles after the accept edge.
//
// Ports
//   CLK, RST      clock and synchronous active-high reset
//   REQ, WE       host request and direction (1 = write), sampled when READY
//   ADDR_IN       host address, latched at accept
//   WDATA         host write data, latched at accept
//   READY         idle, a request will be accepted on the next edge
//   DONE          one-cycle pulse in the last cycle of a transaction
//   RDATA         most recent read word, held until the next read completes
//   RVALID        one-cycle pulse with DONE on reads
//   CS_, OE, WS   RAM chip select (low), output enable, write strobe
//   ADDR          RAM address
//   DATA          shared data bus, driven by the master only on the write path
module ram_bus_master #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ,
  input  logic             WE,
  input  logic [AW-1:0]    ADDR_IN,
  input  logic [WIDTH-1:0] WDATA,
  output logic             READY,
  output logic             DONE,
  output logic [WIDTH-1:0] RDATA,
  output logic             RVALID,
  output logic             CS_,
  output logic             OE,
  output logic             WS,
  output logic [AW-1:0]    ADDR,
  inout  wire  [WIDTH-1:0] DATA
);

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_STROBE,
    W_HOLD,
    R_EN,
    R_SAMPLE,
    R_TURN
  } state_t;

  state_t           state_q, state_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             rvalid_q, rvalid_d;
  logic             cs_n_q, cs_n_d;
  logic             oe_q, oe_d;
  logic             ws_q, ws_d;
  logic             drv_q, drv_d;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] rdata_q;
  logic             accept;

  // Pin values are decoded from the next state and registered, so every
  // output is glitch-free and already valid in the first cycle of a state.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    ready_d  = 1'b0;
    done_d   = 1'b0;
    rvalid_d = 1'b0;
    cs_n_d   = 1'b0;
    oe_d     = 1'b0;
    ws_d     = 1'b0;
    drv_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (REQ && ready_q) begin
          accept  = 1'b1;
          state_d = WE ? W_SETUP : R_EN;
        end
      end
      W_SETUP:  state_d = W_STROBE;
      W_STROBE: state_d = W_HOLD;
      W_HOLD:   state_d = IDLE;
      R_EN:     state_d = R_SAMPLE;
      R_SAMPLE: state_d = R_TURN;
      R_TURN:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    case (state_d)
      IDLE: begin
        cs_n_d  = 1'b1;
        ready_d = 1'b1;
      end
      W_SETUP:  drv_d = 1'b1;
      W_STROBE: begin
        drv_d = 1'b1;
        ws_d  = 1'b1;
      end
      W_HOLD: begin
        drv_d  = 1'b1;
        done_d = 1'b1;
      end
      R_EN:     oe_d = 1'b1;
      R_SAMPLE: oe_d = 1'b1;
      R_TURN: begin
        // Chip deselected with no driver: gives the RAM a full cycle to
        // release DATA before any following write turns the bus around.
        cs_n_d   = 1'b1;
        done_d   = 1'b1;
        rvalid_d = 1'b1;
      end
      default: begin
        cs_n_d  = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
      cs_n_q   <= 1'b1;
      oe_q     <= 1'b0;
      ws_q     <= 1'b0;
      drv_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
      cs_n_q   <= cs_n_d;
      oe_q     <= oe_d;
      ws_q     <= ws_d;
      drv_q    <= drv_d;
      if (accept) begin
        addr_q  <= ADDR_IN;
        wdata_q <= WDATA;
      end
      if (state_q == R_SAMPLE) begin
        rdata_q <= DATA;
      end
    end
  end

  assign DATA   = drv_q ? wdata_q : 'z;
  assign READY  = ready_q;
  assign DONE   = done_q;
  assign RVALID = rvalid_q;
  assign RDATA  = rdata_q;
  assign CS_    = cs_n_q;
  assign OE     = oe_q;
  assign WS     = ws_q;
  assign ADDR   = addr_q;

endmodule
